// File: rtl/spi_responder.sv
// spi_responder: SPI target that shifts WORD_WIDTH-bit frames MSB first, with the SPI pins synchronised into clk_i.
// Latency: pin edge -> internal event 3 clk_i cycles; rx_valid_o/rx_data_o 1 cycle after the last sampling event.
// Backpressure: 1-entry TX buffer gated by tx_ready_o (an empty buffer sends FILL_WORD + underrun_o); no RX backpressure.
// Optional feature: define SPI_RESPONDER_MODE_EN to add cpol_i/cpha_i (SPI modes 0..3); otherwise fixed mode 0.
module spi_responder #(
   parameter int unsigned           WORD_WIDTH = 8,
   parameter logic [WORD_WIDTH-1:0] FILL_WORD  = '1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sclk_i,
   input  logic                  ss_ni,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
`ifdef SPI_RESPONDER_MODE_EN
   input  logic                  cpol_i,
   input  logic                  cpha_i,
`endif
   input  logic [WORD_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [WORD_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   output logic                  underrun_o,
   output logic                  busy_o
);

   localparam int unsigned CW = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            sclk_q, ss_q;
   logic [1:0]            mosi_q;
   logic                  sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
   logic                  sample_ev, shift_ev, hold_first;
   logic                  start, stop, active;
   logic                  do_sample, shift_raw, do_shift, do_load, wr_acc;
   logic [WORD_WIDTH-1:0] tx_buf_q, tx_sh_q, rx_sh_q;
   logic                  buf_full_q, load_pend_q, first_q;
   logic [CW-1:0]         cnt_q;

   // Two-flop synchronisers plus a third flop on sclk/ss for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_q <= '0;
         ss_q   <= '1;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk_i};
         ss_q   <= {ss_q[1:0], ss_ni};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign mosi_s    = mosi_q[1];

`ifdef SPI_RESPONDER_MODE_EN
   logic cpol_q, cpha_q;
   logic lead_ev, trail_ev;

   // Mode inputs are tracked only while idle and frozen for the whole selection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
      end else if (state_q == IDLE) begin
         cpol_q <= cpol_i;
         cpha_q <= cpha_i;
      end
   end

   assign lead_ev    = cpol_q ? sclk_fall : sclk_rise;
   assign trail_ev   = cpol_q ? sclk_rise : sclk_fall;
   assign sample_ev  = cpha_q ? trail_ev : lead_ev;
   assign shift_ev   = cpha_q ? lead_ev : trail_ev;
   // With cpha=1 the MSB is already on MISO, so the first leading edge must not shift.
   assign hold_first = cpha_q;
`else
   assign sample_ev  = sclk_rise;
   assign shift_ev   = sclk_fall;
   assign hold_first = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: select starts a frame, deselect aborts from any bit position.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      stop    = 1'b0;
      case (state_q)
         IDLE:    if (ss_fall) begin state_d = ACTIVE; start = 1'b1; end
         ACTIVE:  if (ss_rise) begin state_d = IDLE;   stop  = 1'b1; end
         default: state_d = IDLE;
      endcase
   end

   // A deselect in the same cycle as an SCLK edge suppresses that edge.
   assign active    = (state_q == ACTIVE) & ~ss_rise;
   assign do_sample = active & sample_ev;
   assign shift_raw = active & shift_ev;
   assign do_shift  = shift_raw & ~(first_q & hold_first);
   assign do_load   = start | (do_shift & load_pend_q);
   // A write is accepted only into an empty buffer; a same-cycle load sees the old (empty) state.
   assign wr_acc    = tx_valid_i & ~buf_full_q;

   // TX buffer and shifter: load on frame start or pending reload, else shift on the shift edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_buf_q   <= '0;
         buf_full_q <= 1'b0;
         tx_sh_q    <= '0;
         underrun_o <= 1'b0;
      end else begin
         underrun_o <= do_load & ~buf_full_q;
         if (do_load & buf_full_q) begin
            buf_full_q <= 1'b0;
         end else if (wr_acc) begin
            buf_full_q <= 1'b1;
            tx_buf_q   <= tx_data_i;
         end
         if (do_load)       tx_sh_q <= buf_full_q ? tx_buf_q : FILL_WORD;
         else if (do_shift) tx_sh_q <= {tx_sh_q[WORD_WIDTH-2:0], 1'b0};
      end
   end

   // RX shifter, bit counter and word-completion bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_sh_q     <= '0;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         cnt_q       <= '0;
         load_pend_q <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         if (start | stop) begin
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            first_q     <= start;
         end else begin
            if (shift_raw) first_q <= 1'b0;
            if (do_shift)  load_pend_q <= 1'b0;
            if (do_sample) begin
               rx_sh_q <= {rx_sh_q[WORD_WIDTH-2:0], mosi_s};
               if (cnt_q == LAST_BIT) begin
                  rx_data_o   <= {rx_sh_q[WORD_WIDTH-2:0], mosi_s};
                  rx_valid_o  <= 1'b1;
                  cnt_q       <= '0;
                  load_pend_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign busy_o     = (state_q == ACTIVE);
   assign miso_oe_o  = busy_o;
   assign miso_o     = busy_o & tx_sh_q[WORD_WIDTH-1];
   assign tx_ready_o = ~buf_full_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: self-checking bench for spi_responder (WORD_WIDTH=8, FILL_WORD=8'hFF).
// A bit-banged SPI initiator drives frames; expected RX words and MISO words go through queues.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_spi_responder;

   localparam int H = 8;   // SCLK half period in clk cycles

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       sclk_i = 1'b0;
   logic       ss_ni = 1'b1;
   logic       mosi_i = 1'b0;
   logic       miso_o, miso_oe_o;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [7:0] tx_data_i = '0;
   logic       tx_valid_i = 1'b0;
   logic       tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, underrun_o, busy_o;

   int         n_tests = 0;
   int         n_fail = 0;
   int         n_rxv = 0;
   int         n_und = 0;
   int         rxv0, und0;
   logic [7:0] rx_q[$];
   logic [7:0] mi_q[$];

   always #5 clk = ~clk;

   spi_responder #(.WORD_WIDTH(8), .FILL_WORD(8'hFF)) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .sclk_i(sclk_i),
      .ss_ni(ss_ni),
      .mosi_i(mosi_i),
      .miso_o(miso_o),
      .miso_oe_o(miso_oe_o),
`ifdef SPI_RESPONDER_MODE_EN
      .cpol_i(cpol),
      .cpha_i(cpha),
`endif
      .tx_data_i(tx_data_i),
      .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o),
      .rx_valid_o(rx_valid_o),
      .underrun_o(underrun_o),
      .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Received words are checked against the scoreboard as the DUT reports them.
   always @(negedge clk) begin
      if (rst_ni && rx_valid_o) begin
         n_rxv++;
         if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
         else                  check("rx_data", 32'(rx_data_o), 32'(rx_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_ni && underrun_o) n_und++;
   end

   task automatic write_tx(input logic [7:0] d);
      tx_data_i  = d;
      tx_valid_i = 1'b1;
      cyc(1);
      tx_valid_i = 1'b0;
   endtask

   task automatic select();
      ss_ni = 1'b0;
      cyc(H);
   endtask

   task automatic deselect();
      ss_ni = 1'b1;
      cyc(H);
   endtask

   // One frame of nbits from the initiator side; only complete frames are scored.
   task automatic frame(input logic [7:0] mo, input logic [7:0] exp_mi, input int nbits, input string tag);
      logic [7:0] got;
      got = '0;
      if (nbits == 8) begin
         rx_q.push_back(mo);
         mi_q.push_back(exp_mi);
      end
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) mosi_i = mo[7-i];
         cyc(H);
         sclk_i = ~cpol;
         if (!cpha) got = {got[6:0], miso_o};
         else       mosi_i = mo[7-i];
         cyc(H);
         sclk_i = cpol;
         if (cpha) got = {got[6:0], miso_o};
      end
      cyc(H);
      if (nbits == 8) check({tag, "_miso"}, 32'(got), 32'(mi_q.pop_front()));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     32'(miso_o),     0);
      check({tag, "_miso_oe"},  32'(miso_oe_o),  0);
      check({tag, "_tx_ready"}, 32'(tx_ready_o), 1);
      check({tag, "_rx_data"},  32'(rx_data_o),  0);
      check({tag, "_rx_valid"}, 32'(rx_valid_o), 0);
      check({tag, "_underrun"}, 32'(underrun_o), 0);
      check({tag, "_busy"},     32'(busy_o),     0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(2);
      check_reset_outputs("rst0");
      rst_ni = 1'b1;
      cyc(4);

      // Single frame: 0xA5 out, 0x3C in; the reload after the last fall underruns.
      write_tx(8'hA5);
      check("t2_ready_full", 32'(tx_ready_o), 0);
      rxv0 = n_rxv; und0 = n_und;
      select();
      check("t2_ready_after_ss", 32'(tx_ready_o), 1);
      check("t2_oe", 32'(miso_oe_o), 1);
      check("t2_busy", 32'(busy_o), 1);
      frame(8'h3C, 8'hA5, 8, "t2");
      deselect();
      check("t2_rx_data", 32'(rx_data_o), 32'h3C);
      check("t2_rx_pulses", 32'(n_rxv - rxv0), 1);
      check("t2_underruns", 32'(n_und - und0), 1);
      check("t2_idle_oe", 32'(miso_oe_o), 0);

      // Back-to-back frames under one select, buffer refilled each frame.
      write_tx(8'h11);
      rxv0 = n_rxv; und0 = n_und;
      select();
      write_tx(8'h22);
      frame(8'h96, 8'h11, 8, "t3a");
      write_tx(8'h33);
      frame(8'h69, 8'h22, 8, "t3b");
      deselect();
      check("t3_rx_pulses", 32'(n_rxv - rxv0), 2);
      check("t3_underruns", 32'(n_und - und0), 0);
      check("t3_rx_data", 32'(rx_data_o), 32'h69);

      // Underrun: empty buffer at select sends FILL_WORD.
      rxv0 = n_rxv; und0 = n_und;
      select();
      check("t4_underrun_at_ss", 32'(n_und - und0), 1);
      frame(8'hC7, 8'hFF, 8, "t4");
      deselect();
      check("t4_rx_data", 32'(rx_data_o), 32'hC7);
      check("t4_underruns", 32'(n_und - und0), 2);

      // Abort after 5 bits, then a clean frame must restart the counter.
      rxv0 = n_rxv;
      select();
      frame(8'hE0, 8'hFF, 5, "t5a");
      deselect();
      check("t5_abort_no_rx", 32'(n_rxv - rxv0), 0);
      select();
      frame(8'h81, 8'hFF, 8, "t5b");
      deselect();
      check("t5_rx_data", 32'(rx_data_o), 32'h81);

`ifdef SPI_RESPONDER_MODE_EN
      for (int m = 0; m < 4; m++) begin
         cpol = m[1];
         cpha = m[0];
         sclk_i = cpol;
         cyc(H);
         write_tx(8'hC3);
         select();
         frame(8'h5A, 8'hC3, 8, $sformatf("t6_m%0d", m));
         deselect();
         check($sformatf("t6_m%0d_rx", m), 32'(rx_data_o), 32'h5A);
      end
      cpol = 1'b0;
      cpha = 1'b0;
      sclk_i = 1'b0;
      cyc(H);
`endif

      // Reset mid-frame: outputs return to reset values immediately.
      write_tx(8'h5A);
      select();
      frame(8'h00, 8'h00, 3, "t1");
      check("t1_busy_before", 32'(busy_o), 1);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("t1_rst");
      ss_ni = 1'b1;
      sclk_i = 1'b0;
      mosi_i = 1'b0;
      cyc(2);
      rst_ni = 1'b1;
      cyc(4);
      check("t1_busy_after", 32'(busy_o), 0);

      check("rx_queue_drained", 32'(rx_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
